// File: rtl/l1_l2_req_scheduler.sv
`timescale 1ns/1ps
// l1_l2_req_scheduler
//
// Arbitrates line requests from the L1 instruction cache (reads only) and the
// L1 data cache (reads and write-backs) onto a single L2 request port. Only
// one L2 transaction is ever in flight. The D side has fixed priority. The I
// side cannot be starved for more than STARVE_MAX consecutive D grants.
//
// Handshake: a requester raises read/write and holds it, with a stable
// address and line, until its one-cycle resp pulse. It must drop the request
// in the cycle after resp. Toward L2 the scheduler holds l2_read or l2_write
// until the one-cycle l2_resp. l2_resp seen outside ISSUE is ignored.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   i_read, i_addr               I-cache line read request
//   i_rdata, i_resp              line and completion pulse back to the I-cache
//   d_read, d_write, d_addr,
//   d_wdata                      D-cache line read / write-back request
//   d_rdata, d_resp              line and completion pulse back to the D-cache
//   l2_read, l2_write, l2_addr,
//   l2_wdata                     request to L2, driven only from latched state
//   l2_rdata, l2_resp            L2 read line and completion pulse
//
// Optional build macro SCHED_WB_BUFFER_EN adds a one-entry write-back buffer.
// It absorbs D writes without an L2 access, serves reads that hit the
// buffered line directly, and drains to L2 when no read is pending.
//
// Debug visibility: state_q, owner_q and starve_cnt_q are plain named
// registers, so checkers can bind to them directly.

module l1_l2_req_scheduler #(
    parameter int ADDR_W     = 32,
    parameter int LINE_W     = 256,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              l2_read,
    output logic              l2_write,
    output logic [ADDR_W-1:0] l2_addr,
    output logic [LINE_W-1:0] l2_wdata,
    input  logic [LINE_W-1:0] l2_rdata,
    input  logic              l2_resp
);

    localparam int                 CNT_W      = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0]   STARVE_LIM = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    // OWN_WB marks a buffer drain: it uses L2 but answers no requester.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2,
        OWN_WB   = 2'd3
    } owner_t;

    state_t              state_q, state_d;
    owner_t              owner_q, owner_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LINE_W-1:0]   wdata_q, wdata_d;
    logic [CNT_W-1:0]    starve_cnt_q, starve_cnt_d;
    logic [LINE_W-1:0]   i_rdata_q, i_rdata_d;
    logic [LINE_W-1:0]   d_rdata_q, d_rdata_d;

`ifdef SCHED_WB_BUFFER_EN
    logic                wb_valid_q, wb_valid_d;
    logic [ADDR_W-1:0]   wb_addr_q, wb_addr_d;
    logic [LINE_W-1:0]   wb_line_q, wb_line_d;
`endif

    logic d_req;
    logic force_i;
    logic grant_d;
    logic grant_i;

    // Winner selection is a pure function of the live requests and the
    // starvation counter. It is only acted on in IDLE.
    assign d_req   = d_read | d_write;
    assign force_i = i_read && (starve_cnt_q == STARVE_LIM);
    assign grant_d = d_req && !force_i;
    assign grant_i = i_read && !grant_d;

    // ------------------------------------------------------------------
    // State register (plus the datapath registers it carries along)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_NONE;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            starve_cnt_q <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
`ifdef SCHED_WB_BUFFER_EN
            wb_valid_q   <= 1'b0;
            wb_addr_q    <= '0;
            wb_line_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            starve_cnt_q <= starve_cnt_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
`ifdef SCHED_WB_BUFFER_EN
            wb_valid_q   <= wb_valid_d;
            wb_addr_q    <= wb_addr_d;
            wb_line_q    <= wb_line_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        starve_cnt_d = starve_cnt_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
`ifdef SCHED_WB_BUFFER_EN
        wb_valid_d   = wb_valid_q;
        wb_addr_d    = wb_addr_q;
        wb_line_d    = wb_line_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (grant_d) begin
                    owner_d = OWN_D;
                    // A combined read+write request is handled as a write.
                    wr_d    = d_write;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                    state_d = S_ISSUE;
                    // Count D grants only while I is actually waiting.
                    if (!i_read) begin
                        starve_cnt_d = '0;
                    end else if (starve_cnt_q != STARVE_LIM) begin
                        starve_cnt_d = starve_cnt_q + 1'b1;
                    end
                end else if (grant_i) begin
                    owner_d      = OWN_I;
                    wr_d         = 1'b0;
                    addr_d       = i_addr;
                    starve_cnt_d = '0;
                    state_d      = S_ISSUE;
                end
`ifdef SCHED_WB_BUFFER_EN
                // The buffer decisions below override the plain path above.
                if (grant_d && d_write && wb_valid_q) begin
                    // Buffer occupied: drain it now, and the D write is taken
                    // on a later IDLE pass. This is not a D grant.
                    owner_d      = OWN_WB;
                    wr_d         = 1'b1;
                    addr_d       = wb_addr_q;
                    wdata_d      = wb_line_q;
                    starve_cnt_d = starve_cnt_q;
                    state_d      = S_ISSUE;
                end else if (grant_d && d_write) begin
                    wb_valid_d = 1'b1;
                    wb_addr_d  = d_addr;
                    wb_line_d  = d_wdata;
                    state_d    = S_RESP;
                end else if (grant_d && wb_valid_q && (d_addr == wb_addr_q)) begin
                    d_rdata_d = wb_line_q;
                    state_d   = S_RESP;
                end else if (grant_i && wb_valid_q && (i_addr == wb_addr_q)) begin
                    i_rdata_d = wb_line_q;
                    state_d   = S_RESP;
                end else if (!grant_d && !grant_i && wb_valid_q) begin
                    owner_d = OWN_WB;
                    wr_d    = 1'b1;
                    addr_d  = wb_addr_q;
                    wdata_d = wb_line_q;
                    state_d = S_ISSUE;
                end
`endif
            end

            S_ISSUE: begin
                if (l2_resp) begin
                    state_d = S_RESP;
                    // Write completions leave both rdata registers untouched.
                    if (!wr_q && owner_q == OWN_I) begin
                        i_rdata_d = l2_rdata;
                    end
                    if (!wr_q && owner_q == OWN_D) begin
                        d_rdata_d = l2_rdata;
                    end
`ifdef SCHED_WB_BUFFER_EN
                    if (owner_q == OWN_WB) begin
                        wb_valid_d = 1'b0;
                    end
`endif
                end
            end

            S_RESP: begin
                owner_d = OWN_NONE;
                state_d = S_IDLE;
            end

            default: begin
                owner_d = OWN_NONE;
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from registers only, never from requester inputs
    // ------------------------------------------------------------------
    always_comb begin
        l2_read  = 1'b0;
        l2_write = 1'b0;
        l2_addr  = '0;
        l2_wdata = '0;
        i_resp   = 1'b0;
        d_resp   = 1'b0;
        if (state_q == S_ISSUE) begin
            l2_read  = !wr_q;
            l2_write = wr_q;
            l2_addr  = addr_q;
            l2_wdata = wr_q ? wdata_q : '0;
        end
        if (state_q == S_RESP) begin
            i_resp = (owner_q == OWN_I);
            d_resp = (owner_q == OWN_D);
        end
    end

    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_l1_l2_req_scheduler.sv
`timescale 1ns/1ps
// Directed testbench for l1_l2_req_scheduler, default build with no
// write-back buffer. Inputs are driven at the falling edge. Outputs are
// sampled at the falling edge, away from the active rising edge.

module tb_l1_l2_req_scheduler;

    localparam int ADDR_W     = 32;
    localparam int LINE_W     = 256;
    localparam int STARVE_MAX = 4;

    logic              clk;
    logic              rst;
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              l2_read;
    logic              l2_write;
    logic [ADDR_W-1:0] l2_addr;
    logic [LINE_W-1:0] l2_wdata;
    logic [LINE_W-1:0] l2_rdata;
    logic              l2_resp;

    int checks   = 0;
    int failures = 0;

    logic [LINE_W-1:0] exp_i_rdata;
    logic [LINE_W-1:0] exp_d_rdata;

    l1_l2_req_scheduler #(
        .ADDR_W    (ADDR_W),
        .LINE_W    (LINE_W),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_read  (i_read),
        .i_addr  (i_addr),
        .i_rdata (i_rdata),
        .i_resp  (i_resp),
        .d_read  (d_read),
        .d_write (d_write),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_rdata (d_rdata),
        .d_resp  (d_resp),
        .l2_read (l2_read),
        .l2_write(l2_write),
        .l2_addr (l2_addr),
        .l2_wdata(l2_wdata),
        .l2_rdata(l2_rdata),
        .l2_resp (l2_resp)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [LINE_W-1:0] rep8(input logic [7:0] b);
        return {32{b}};
    endfunction

    // ---------------- driver: L2 responder ----------------
    // Waits (bounded) for a request to L2, records it, and keeps it in ISSUE
    // for 'delay' cycles. It then answers with l2_resp in the last of those
    // cycles. It returns at the falling edge of the RESP cycle.
    task automatic l2_serve(input int delay, input logic [LINE_W-1:0] data,
                            output bit ok, output int lat, output int held,
                            output logic [ADDR_W-1:0] addr, output logic rd,
                            output logic wr, output logic [LINE_W-1:0] wd);
        ok = 0; lat = -1; held = 0; addr = '0; rd = 0; wr = 0; wd = '0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (l2_read || l2_write) begin
                ok  = 1;
                lat = i;
            end
        end
        if (ok) begin
            addr = l2_addr; rd = l2_read; wr = l2_write; wd = l2_wdata;
            for (int k = 0; k < delay; k++) begin
                if (k > 0) @(negedge clk);
                if ((l2_read || l2_write) && l2_addr == addr) held++;
                if (k == delay - 1) begin
                    l2_resp  = 1'b1;
                    l2_rdata = data;
                end
            end
            @(negedge clk);
            l2_resp  = 1'b0;
            l2_rdata = '0;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bit any_resp;
        rst = 1'b1;
        i_read = 0; i_addr = '0; d_read = 0; d_write = 0; d_addr = '0; d_wdata = '0;
        l2_rdata = '0; l2_resp = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({l2_read, l2_write, i_resp, d_resp} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected 0000", {l2_read, l2_write, i_resp, d_resp});
        end
        checks++;
        if (l2_addr !== '0 || l2_wdata !== '0 || i_rdata !== '0 || d_rdata !== '0) begin
            failures++;
            $display("FAIL reset_data: l2_addr=%h i_rdata=%h d_rdata=%h expected all 0", l2_addr, i_rdata, d_rdata);
        end
        checks++;
        if (dut.state_q !== 2'd0 || dut.starve_cnt_q !== 3'd0) begin
            failures++;
            $display("FAIL reset_state: state=%0d starve=%0d expected 0/0", dut.state_q, dut.starve_cnt_q);
        end
        // A stray l2_resp while idle must not produce any response.
        l2_resp = 1'b1; l2_rdata = rep8(8'h99);
        @(negedge clk);
        l2_resp = 1'b0; l2_rdata = '0;
        any_resp = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i_resp || d_resp || l2_read || l2_write) any_resp = 1;
        end
        checks++;
        if (any_resp !== 1'b0 || i_rdata !== '0) begin
            failures++;
            $display("FAIL stray_l2_resp: activity=%b i_rdata=%h expected 0", any_resp, i_rdata);
        end
    endtask

    task automatic test_i_only();
        bit ok; int lat, held; logic [ADDR_W-1:0] a; logic rd, wr; logic [LINE_W-1:0] wd;
        i_read = 1'b1; i_addr = 32'h60;
        l2_serve(5, rep8(8'hAB), ok, lat, held, a, rd, wr, wd);
        exp_i_rdata = rep8(8'hAB);
        checks++;
        if (!ok || lat != 0) begin
            failures++;
            $display("FAIL i_only_latency: ok=%0d lat=%0d expected ok=1 lat=0", ok, lat);
        end
        checks++;
        if (a !== 32'h60 || rd !== 1'b1 || wr !== 1'b0 || held != 5) begin
            failures++;
            $display("FAIL i_only_req: addr=%h rd=%b wr=%b held=%0d expected 60/1/0/5", a, rd, wr, held);
        end
        checks++;
        if (i_resp !== 1'b1 || d_resp !== 1'b0 || l2_read !== 1'b0 || i_rdata !== exp_i_rdata) begin
            failures++;
            $display("FAIL i_only_resp: i_resp=%b d_resp=%b l2_read=%b i_rdata=%h expected 1/0/0/%h",
                     i_resp, d_resp, l2_read, i_rdata, exp_i_rdata);
        end
        i_read = 1'b0;
        @(negedge clk);
        checks++;
        if (i_resp !== 1'b0 || i_rdata !== exp_i_rdata) begin
            failures++;
            $display("FAIL i_only_pulse: i_resp=%b i_rdata=%h expected 0/%h", i_resp, i_rdata, exp_i_rdata);
        end
    endtask

    task automatic test_simultaneous();
        bit ok; int lat, held; logic [ADDR_W-1:0] a; logic rd, wr; logic [LINE_W-1:0] wd;
        i_read = 1'b1; i_addr = 32'h60; d_read = 1'b1; d_addr = 32'h100;
        l2_serve(1, rep8(8'hD1), ok, lat, held, a, rd, wr, wd);
        exp_d_rdata = rep8(8'hD1);
        checks++;
        if (!ok || a !== 32'h100 || rd !== 1'b1) begin
            failures++;
            $display("FAIL simul_d_first: ok=%0d addr=%h rd=%b expected 1/100/1", ok, a, rd);
        end
        checks++;
        if (d_resp !== 1'b1 || i_resp !== 1'b0 || d_rdata !== exp_d_rdata) begin
            failures++;
            $display("FAIL simul_d_resp: d_resp=%b i_resp=%b d_rdata=%h expected 1/0/%h", d_resp, i_resp, d_rdata, exp_d_rdata);
        end
        d_read = 1'b0;
        l2_serve(2, rep8(8'h11), ok, lat, held, a, rd, wr, wd);
        exp_i_rdata = rep8(8'h11);
        checks++;
        if (!ok || a !== 32'h60 || rd !== 1'b1) begin
            failures++;
            $display("FAIL simul_i_second: ok=%0d addr=%h rd=%b expected 1/60/1", ok, a, rd);
        end
        checks++;
        if (i_resp !== 1'b1 || d_resp !== 1'b0 || i_rdata !== exp_i_rdata || d_rdata !== exp_d_rdata) begin
            failures++;
            $display("FAIL simul_i_resp: i_resp=%b d_resp=%b i_rdata=%h d_rdata=%h", i_resp, d_resp, i_rdata, d_rdata);
        end
        i_read = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_starvation();
        bit ok; int lat, held; logic [ADDR_W-1:0] a; logic rd, wr; logic [LINE_W-1:0] wd;
        logic [ADDR_W-1:0] cur_d;
        logic [2:0] exp_cnt;
        bit exp_i;
        logic [LINE_W-1:0] data;
        cur_d = 32'h1000;
        i_read = 1'b1; i_addr = 32'h60; d_read = 1'b1; d_addr = cur_d;
        for (int g = 0; g < 6; g++) begin
            exp_i   = (g == 4);
            exp_cnt = (g < 4) ? 3'(g + 1) : 3'd0;
            data    = rep8(8'h10 + 8'(g));
            l2_serve(1, data, ok, lat, held, a, rd, wr, wd);
            checks++;
            if (!ok || a !== (exp_i ? 32'h60 : cur_d)) begin
                failures++;
                $display("FAIL starve_grant%0d: ok=%0d addr=%h expected %h", g, ok, a, exp_i ? 32'h60 : cur_d);
            end
            checks++;
            if (i_resp !== exp_i || d_resp !== !exp_i || dut.starve_cnt_q !== exp_cnt) begin
                failures++;
                $display("FAIL starve_resp%0d: i_resp=%b d_resp=%b starve=%0d expected %b/%b/%0d",
                         g, i_resp, d_resp, dut.starve_cnt_q, exp_i, !exp_i, exp_cnt);
            end
            if (exp_i) begin
                exp_i_rdata = data;
                i_read = 1'b0;
            end else begin
                exp_d_rdata = data;
                d_read = 1'b0;
                if (g < 5) begin
                    @(negedge clk);
                    cur_d  = cur_d + 32'h40;
                    d_addr = cur_d;
                    d_read = 1'b1;
                end
            end
        end
        checks++;
        if (i_rdata !== exp_i_rdata || d_rdata !== exp_d_rdata) begin
            failures++;
            $display("FAIL starve_rdata: i_rdata=%h d_rdata=%h expected %h/%h", i_rdata, d_rdata, exp_i_rdata, exp_d_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_rw_together();
        bit ok; int lat, held; logic [ADDR_W-1:0] a; logic rd, wr; logic [LINE_W-1:0] wd;
        d_read = 1'b1; d_write = 1'b1; d_addr = 32'h300; d_wdata = rep8(8'h55);
        l2_serve(2, rep8(8'hEE), ok, lat, held, a, rd, wr, wd);
        checks++;
        if (!ok || rd !== 1'b0 || wr !== 1'b1 || a !== 32'h300 || wd !== rep8(8'h55)) begin
            failures++;
            $display("FAIL rw_as_write: ok=%0d rd=%b wr=%b addr=%h wdata=%h", ok, rd, wr, a, wd);
        end
        checks++;
        if (d_resp !== 1'b1 || d_rdata !== exp_d_rdata) begin
            failures++;
            $display("FAIL rw_resp: d_resp=%b d_rdata=%h expected 1/%h", d_resp, d_rdata, exp_d_rdata);
        end
        d_read = 1'b0; d_write = 1'b0; d_wdata = '0;
        @(negedge clk);
    endtask

    task automatic test_reset_in_issue();
        bit ok; int lat, held; logic [ADDR_W-1:0] a; logic rd, wr; logic [LINE_W-1:0] wd;
        bit seen, any_resp;
        i_read = 1'b1; i_addr = 32'h80;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (l2_read) seen = 1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL rst_issue_reach: l2_read never seen, expected 1");
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({l2_read, l2_write, i_resp, d_resp} !== 4'b0000 || l2_addr !== '0 || i_rdata !== '0 || d_rdata !== '0) begin
            failures++;
            $display("FAIL rst_issue_async: ctrl=%b l2_addr=%h i_rdata=%h d_rdata=%h expected all 0",
                     {l2_read, l2_write, i_resp, d_resp}, l2_addr, i_rdata, d_rdata);
        end
        @(negedge clk);
        i_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        any_resp = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i_resp || d_resp || l2_read || l2_write) any_resp = 1;
        end
        checks++;
        if (any_resp !== 1'b0) begin
            failures++;
            $display("FAIL rst_issue_noresp: activity=%b expected 0", any_resp);
        end
        i_read = 1'b1; i_addr = 32'h40;
        l2_serve(2, rep8(8'h3C), ok, lat, held, a, rd, wr, wd);
        checks++;
        if (!ok || a !== 32'h40 || i_resp !== 1'b1 || i_rdata !== rep8(8'h3C) || d_rdata !== '0) begin
            failures++;
            $display("FAIL rst_issue_fresh: ok=%0d addr=%h i_resp=%b i_rdata=%h d_rdata=%h", ok, a, i_resp, i_rdata, d_rdata);
        end
        i_read = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        exp_i_rdata = '0;
        exp_d_rdata = '0;
        test_reset();
        test_i_only();
        test_simultaneous();
        test_starvation();
        test_rw_together();
        test_reset_in_issue();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
